// File: rtl/ram_32kx4_dp_pkg.sv
// ram_32kx4_dp_pkg: shared constants and types for the 32K x 4 true dual-port RAM.
//   ADDR_W / DATA_W / DEPTH : geometry (DEPTH is tied to ADDR_W)
//   addr_t / data_t         : port address and word types
//   rw_e                    : per-port operation select (RW_READ / RW_WRITE)
package ram_32kx4_dp_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  // True when both ports write the same word in one cycle; port 2 must then yield.
  function automatic logic ww_collision(input rw_e rw_a, input rw_e rw_b,
                                        input addr_t addr_a, input addr_t addr_b);
    return (rw_a == RW_WRITE) && (rw_b == RW_WRITE) && (addr_a == addr_b);
  endfunction

endpackage

// File: rtl/ram_32kx4_dp_port_reg.sv
// ram_dp_port_reg: per-port registered read-data output.
//   clk       : clock, rising edge active
//   rst_n     : asynchronous active-low reset, clears the output to 0
//   rw_i      : operation select; the register loads only on RW_READ
//   rd_data_i : word currently addressed in the array (pre-write contents)
//   data_q_o  : registered read data, held across write cycles
module ram_dp_port_reg
  import ram_32kx4_dp_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  rw_e   rw_i,
  input  data_t rd_data_i,
  output data_t data_q_o
);

  data_t data_d;
  data_t data_q;

  // Next-state: capture array data on a read, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (rw_i == RW_READ) begin
      data_d = rd_data_i;
    end else begin
      data_d = data_q;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {DATA_W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign data_q_o = data_q;

endmodule

// File: rtl/ram_32kx4_dp.sv
// ram_32kx4_dp: 32768 x 4 true dual-port synchronous RAM, single clock.
//   clk                    : clock; writes and read registers update on the rising edge
//   rst_n                  : asynchronous active-low reset (outputs cleared, writes blocked)
//   data_in_1 / data_in_2  : per-port write data
//   rw_1 / rw_2            : per-port select, 1 = write, 0 = read
//   address_1 / address_2  : per-port word address
//   data_out_1 / data_out_2: per-port registered read data (one-cycle latency)
// Same-address collisions: port 1 wins write/write; a read concurrent with a
// write on the other port returns the old contents.
module ram_32kx4_dp
  import ram_32kx4_dp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic              rw_1,
  input  logic              rw_2,
  input  logic [ADDR_W-1:0] address_1,
  input  logic [ADDR_W-1:0] address_2,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2
);

  data_t mem_r [DEPTH];

  rw_e   rw_1_s;
  rw_e   rw_2_s;
  data_t rd_data_1_s;
  data_t rd_data_2_s;
  logic  we_1_s;
  logic  we_2_s;

  assign rw_1_s = rw_e'(rw_1);
  assign rw_2_s = rw_e'(rw_2);

  // Asynchronous array reads feed the output registers; since the array only
  // changes at the edge, the registers capture pre-write data (read-before-write).
  assign rd_data_1_s = mem_r[address_1];
  assign rd_data_2_s = mem_r[address_2];

  // Write enables: gated by reset, port 2 dropped on a same-address write/write.
  always_comb begin
    we_1_s = 1'b0;
    we_2_s = 1'b0;
    if (rst_n) begin
      we_1_s = (rw_1_s == RW_WRITE);
      we_2_s = (rw_2_s == RW_WRITE) &&
               !ww_collision(rw_1_s, rw_2_s, address_1, address_2);
    end else begin
      we_1_s = 1'b0;
      we_2_s = 1'b0;
    end
  end

  // Array write ports; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_1_s) begin
      mem_r[address_1] <= data_in_1;
    end
    if (we_2_s) begin
      mem_r[address_2] <= data_in_2;
    end
  end

  ram_dp_port_reg u_port_reg_1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rw_i      (rw_1_s),
    .rd_data_i (rd_data_1_s),
    .data_q_o  (data_out_1)
  );

  ram_dp_port_reg u_port_reg_2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rw_i      (rw_2_s),
    .rd_data_i (rd_data_2_s),
    .data_q_o  (data_out_2)
  );

endmodule

// File: tb/tb_ram_32kx4_dp.sv
// tb_ram_32kx4_dp: directed self-checking bench for ram_32kx4_dp.
module tb_ram_32kx4_dp;

  logic        clk;
  logic        rst_n;
  logic [3:0]  data_in_1;
  logic [3:0]  data_in_2;
  logic        rw_1;
  logic        rw_2;
  logic [14:0] address_1;
  logic [14:0] address_2;
  logic [3:0]  data_out_1;
  logic [3:0]  data_out_2;

  int chk_cnt;
  int pass_cnt;

  ram_32kx4_dp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .rw_1       (rw_1),
    .rw_2       (rw_2),
    .address_1  (address_1),
    .address_2  (address_2),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation per port at the falling edge, then step past the rising edge.
  task automatic op(input logic r1, input logic [14:0] a1, input logic [3:0] d1,
                    input logic r2, input logic [14:0] a2, input logic [3:0] d2);
    @(negedge clk);
    rw_1 = r1; address_1 = a1; data_in_1 = d1;
    rw_2 = r2; address_2 = a2; data_in_2 = d2;
    @(posedge clk);
    #1;
  endtask

  task automatic check2(input string tag, input logic [3:0] e1, input logic [3:0] e2);
    check({tag, "_p1"}, data_out_1, e1);
    check({tag, "_p2"}, data_out_2, e2);
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    rw_1      = 1'b0;
    rw_2      = 1'b0;
    address_1 = 15'd0;
    address_2 = 15'd0;
    data_in_1 = 4'h0;
    data_in_2 = 4'h0;

    repeat (2) @(posedge clk);
    #1;
    check2("reset", 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read: outputs hold 0 across the writes.
    op(1'b1, 15'd250, 4'd10, 1'b1, 15'd251, 4'd10);
    check2("wr1_hold", 4'h0, 4'h0);
    op(1'b1, 15'd250, 4'd11, 1'b1, 15'd251, 4'd11);
    check2("wr2_hold", 4'h0, 4'h0);
    op(1'b0, 15'd250, 4'h0, 1'b0, 15'd251, 4'h0);
    check2("basic_rd", 4'hB, 4'hB);

    // Mid-run reset clears outputs without a clock edge and blocks writes.
    rw_1 = 1'b1; address_1 = 15'd250; data_in_1 = 4'h0;
    rw_2 = 1'b1; address_2 = 15'd251; data_in_2 = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    check2("async_rst", 4'h0, 4'h0);
    @(posedge clk);
    #1;
    check2("rst_hold", 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rw_1  = 1'b0;
    rw_2  = 1'b0;
    @(posedge clk);
    #1;
    check2("mem_kept", 4'hB, 4'hB);

    // Cross-port read.
    op(1'b1, 15'd100, 4'h5, 1'b0, 15'd250, 4'h0);
    check2("xport_wr", 4'hB, 4'hB);
    op(1'b0, 15'd251, 4'h0, 1'b0, 15'd100, 4'h0);
    check2("xport_rd", 4'hB, 4'h5);

    // Write/write collision: port 1 wins; then read/read of the same word.
    op(1'b1, 15'd7, 4'h3, 1'b1, 15'd7, 4'hC);
    check2("ww_hold", 4'hB, 4'h5);
    op(1'b0, 15'd7, 4'h0, 1'b0, 15'd7, 4'h0);
    check2("ww_rd", 4'h3, 4'h3);

    // Read-during-write returns old data; new data visible next read.
    op(1'b1, 15'd20, 4'h1, 1'b0, 15'd100, 4'h0);
    check2("rdw_init", 4'h3, 4'h5);
    op(1'b1, 15'd20, 4'h9, 1'b0, 15'd20, 4'h0);
    check2("rdw_old", 4'h3, 4'h1);
    op(1'b0, 15'd20, 4'h0, 1'b0, 15'd20, 4'h0);
    check2("rdw_new", 4'h9, 4'h9);

    // Boundary addresses, read back on both ports.
    op(1'b1, 15'd0, 4'hA, 1'b1, 15'd32767, 4'hF);
    check2("bnd_wr", 4'h9, 4'h9);
    op(1'b0, 15'd0, 4'h0, 1'b0, 15'd32767, 4'h0);
    check2("bnd_rd_a", 4'hA, 4'hF);
    op(1'b0, 15'd32767, 4'h0, 1'b0, 15'd0, 4'h0);
    check2("bnd_rd_b", 4'hF, 4'hA);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ram_32kx4_dp.md
Name: ram_32kx4_dp

Overview:
- True dual-port synchronous RAM: 32768 words x 4 bits, two fully independent read/write ports on one clock.
- Each port has its own address, data-in, read/write select and registered data-out.
- Used as a general-purpose on-chip buffer where two agents need concurrent access to a shared 4-bit-wide store.

Parameters:
- ADDR_W, 15, address width per port.
- DATA_W, 4, word width.
- DEPTH, 2**ADDR_W (32768), number of words. Fixed relationship; not independently overridable.

Ports:
- clk  input  1  single clock; all writes and read registers update on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in_1  input  DATA_W  port 1 write data.
- data_in_2  input  DATA_W  port 2 write data.
- rw_1  input  1  port 1 operation select: 1 = write, 0 = read.
- rw_2  input  1  port 2 operation select: 1 = write, 0 = read.
- address_1  input  ADDR_W  port 1 word address.
- address_2  input  ADDR_W  port 2 word address.
- data_out_1  output  DATA_W  port 1 registered read data.
- data_out_2  output  DATA_W  port 2 registered read data.

Behaviour:
- Reset
  - rst_n low asynchronously forces data_out_1 = 0 and data_out_2 = 0, held while low.
  - Memory array is not cleared by reset; contents of never-written words are undefined.
  - While rst_n is low, writes are suppressed.
  - First active edge is the first rising clk edge with rst_n high.
- Write (rw_x = 1)
  - On the rising edge, mem[address_x] <= data_in_x.
  - data_out_x holds its previous value (no write-through).
- Read (rw_x = 0)
  - On the rising edge, data_out_x <= mem[address_x].
  - Latency: one cycle; value valid after the edge and held until the next read or reset.
- Ports are independent; any mix of operations may occur in the same cycle.
- Collision rules (same cycle, same address)
  - Write/write: port 1 data wins; port 2 write is discarded.
  - Read on one port, write on the other: the read returns the old (pre-write) contents (read-before-write). The new data is visible on the following read.
  - Read/read: both ports return the same stored word.
- Address range
  - Addresses are full-range; no out-of-range condition exists.
  - Addresses 0 and 32767 behave like any other.
- No enable inputs; every clock edge performs the selected operation on both ports.
- Inputs are sampled only at the rising edge. Changes between edges have no effect.

Decomposition:
- Shared package ram_32kx4_dp_pkg
  - Constants: ADDR_W = 15, DATA_W = 4, DEPTH.
  - Typedefs: addr_t (logic [ADDR_W-1:0]), data_t (logic [DATA_W-1:0]).
  - Enum for rw: RW_READ = 0, RW_WRITE = 1.
- One natural sub-module: ram_dp_port_reg, the per-port output register.
  - Async reset to 0; loads read data when rw = 0.
  - Instantiated twice.
- The array and the collision-priority write logic stay in the top module.

Test Plan:
- Reset
  - Stimulus: assert rst_n = 0 mid-simulation after data_out_1 = 4'b1011.
  - Required: both outputs go to 0 immediately, with no clock edge needed.
- Basic write/read
  - Stimulus: rw_1 = 1, address_1 = 250, data_in_1 = 10 and rw_2 = 1, address_2 = 251, data_in_2 = 10 at one edge. At the next edge write 11 to the same addresses. Then rw_1 = rw_2 = 0.
  - Required: after the read edge, data_out_1 = 4'b1011 and data_out_2 = 4'b1011.
  - Required: outputs unchanged (0 after reset) during both write edges.
- Cross-port read
  - Stimulus: port 1 writes 4'h5 to address 100. Next cycle, port 2 reads address 100.
  - Required: data_out_2 = 4'h5 one cycle after the read edge.
- Write/write collision
  - Stimulus: port 1 writes 4'h3 and port 2 writes 4'hC to address 7 in the same cycle. Then port 1 reads address 7.
  - Required: data_out_1 = 4'h3.
- Read-during-write
  - Stimulus: address 20 holds 4'h1. In one cycle, port 1 writes 4'h9 to address 20 while port 2 reads address 20.
  - Required: data_out_2 = 4'h1 after that edge. A port 2 read on the next cycle gives 4'h9.
- Boundary addresses
  - Stimulus: write 4'hA to address 0 and 4'hF to address 32767. Read both back on each port.
  - Required: exact values returned, no aliasing between the two addresses.
